// File: rtl/led_mode_bank.sv
// N-channel LED mode controller: synchronised, debounced buttons or CPU strobes step each
// channel through OFF/ON/BLINK/FAST; a shared prescaler keeps every channel's blink phase aligned.
module led_mode_bank #(
    parameter int unsigned N_CH       = 2,
    parameter int unsigned CNT_W      = 26,
    parameter int unsigned SLOW_BIT   = 25,
    parameter int unsigned FAST_BIT   = 24,
    parameter int unsigned DEB_CYCLES = 1000000,
    parameter int unsigned DEB_W      = 20,
    localparam int unsigned CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   btn_raw_i,
    input  logic [N_CH-1:0]   sw_step_i,
    input  logic              sw_wr_i,
    input  logic [CH_W-1:0]   sw_ch_i,
    input  logic [1:0]        sw_mode_i,
    output logic [N_CH-1:0]   led_o,
    output logic [2*N_CH-1:0] mode_o,
    output logic [N_CH-1:0]   btn_deb_o
);

    typedef enum logic [1:0] {
        ModeOff   = 2'b00,
        ModeOn    = 2'b01,
        ModeBlink = 2'b10,
        ModeFast  = 2'b11
    } mode_e;

    logic [CNT_W-1:0] pre_q, pre_d;
    logic [N_CH-1:0]  sync1_q, sync2_q;

    assign pre_d = pre_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            pre_q   <= pre_d;
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
        logic             deb_q, deb_d;
        logic             deb_prev_q;
        mode_e            mode_q, mode_d;
        logic             led_q, led_d;
        logic             press;
        logic             adv;
        logic             wr_hit;

        // The level must stay different from deb for DEB_CYCLES counts before it is accepted.
        always_comb begin
            deb_cnt_d = deb_cnt_q;
            deb_d     = deb_q;
            if (sync2_q[i] == deb_q) begin
                deb_cnt_d = '0;
            end else if (deb_cnt_q == DEB_W'(DEB_CYCLES)) begin
                deb_d     = sync2_q[i];
                deb_cnt_d = '0;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end

        assign press  = deb_q & ~deb_prev_q;
        assign adv    = press | sw_step_i[i];
        assign wr_hit = sw_wr_i && (sw_ch_i == CH_W'(i));

        always_comb begin
            mode_d = mode_q;
            if (wr_hit) begin
                mode_d = mode_e'(sw_mode_i);
            end else if (adv) begin
                unique case (mode_q)
                    ModeOff:   mode_d = ModeOn;
                    ModeOn:    mode_d = ModeBlink;
                    ModeBlink: mode_d = ModeFast;
                    ModeFast:  mode_d = ModeOff;
                    default:   mode_d = ModeOff;
                endcase
            end
        end

        always_comb begin
            led_d = 1'b0;
            unique case (mode_q)
                ModeOff:   led_d = 1'b0;
                ModeOn:    led_d = 1'b1;
                ModeBlink: led_d = pre_q[SLOW_BIT];
                ModeFast:  led_d = pre_q[FAST_BIT];
                default:   led_d = 1'b0;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                deb_cnt_q  <= '0;
                deb_q      <= 1'b0;
                deb_prev_q <= 1'b0;
                mode_q     <= ModeOff;
                led_q      <= 1'b0;
            end else begin
                deb_cnt_q  <= deb_cnt_d;
                deb_q      <= deb_d;
                deb_prev_q <= deb_q;
                mode_q     <= mode_d;
                led_q      <= led_d;
            end
        end

        assign btn_deb_o[i]      = deb_q;
        assign led_o[i]          = led_q;
        assign mode_o[2*i +: 2]  = mode_q;
    end

endmodule

// File: tb/tb_led_mode_bank.sv
// Directed bench for led_mode_bank: vector table for CPU stepping/writes plus hand sequences for
// debounce latency, glitch rejection, reset, same-cycle merging and blink timing.
module tb_led_mode_bank;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] btn_raw, sw_step, sw_mode, led, btn_deb;
    logic       sw_wr, sw_ch;
    logic [3:0] mode;

    logic [2:0] btn3, step3, led3, deb3;
    logic       wr3;
    logic [1:0] ch3, md3;
    logic [5:0] mode3;

    int         n_checks = 0;
    int         n_err = 0;
    logic [5:0] cnt_model = '0;

    typedef struct {
        logic [1:0] step;
        logic       wr;
        logic       ch;
        logic [1:0] md;
        logic [3:0] exp_mode;
    } vec_t;

    vec_t       vecs[10];
    logic [3:0] press_exp[3];

    led_mode_bank #(
        .N_CH(2), .CNT_W(6), .SLOW_BIT(5), .FAST_BIT(3), .DEB_CYCLES(4), .DEB_W(3)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .btn_raw_i(btn_raw), .sw_step_i(sw_step), .sw_wr_i(sw_wr),
        .sw_ch_i(sw_ch), .sw_mode_i(sw_mode), .led_o(led), .mode_o(mode), .btn_deb_o(btn_deb)
    );

    led_mode_bank #(
        .N_CH(3), .CNT_W(6), .SLOW_BIT(5), .FAST_BIT(3), .DEB_CYCLES(4), .DEB_W(3)
    ) u_dut3 (
        .clk(clk), .rst_n(rst_n), .btn_raw_i(btn3), .sw_step_i(step3), .sw_wr_i(wr3),
        .sw_ch_i(ch3), .sw_mode_i(md3), .led_o(led3), .mode_o(mode3), .btn_deb_o(deb3)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model of the shared prescaler advances with every edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cnt_model = cnt_model + 6'd1;
        end
    endtask

    initial begin
        btn_raw = '0; sw_step = '0; sw_wr = 1'b0; sw_ch = 1'b0; sw_mode = '0;
        btn3 = '0; step3 = '0; wr3 = 1'b0; ch3 = '0; md3 = '0;

        vecs[0] = '{2'b01, 1'b0, 1'b0, 2'b00, 4'b0010};
        vecs[1] = '{2'b11, 1'b0, 1'b0, 2'b00, 4'b0111};
        vecs[2] = '{2'b01, 1'b0, 1'b0, 2'b00, 4'b0100};
        vecs[3] = '{2'b00, 1'b1, 1'b1, 2'b10, 4'b1000};
        vecs[4] = '{2'b01, 1'b1, 1'b0, 2'b11, 4'b1011};
        vecs[5] = '{2'b01, 1'b1, 1'b1, 2'b00, 4'b0000};
        vecs[6] = '{2'b10, 1'b0, 1'b0, 2'b00, 4'b0100};
        vecs[7] = '{2'b00, 1'b0, 1'b0, 2'b00, 4'b0100};
        vecs[8] = '{2'b00, 1'b1, 1'b0, 2'b01, 4'b0101};
        vecs[9] = '{2'b10, 1'b1, 1'b1, 2'b00, 4'b0001};
        press_exp[0] = 4'b0010;
        press_exp[1] = 4'b0011;
        press_exp[2] = 4'b0000;

        tick(2);
        check("reset_led", 8'(led), 8'h0);
        check("reset_mode", 8'(mode), 8'h0);
        check("reset_deb", 8'(btn_deb), 8'h0);
        rst_n = 1'b1;

        // Held button: mode changes on the 8th edge counting the first sampling edge.
        btn_raw[0] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            check("latency_hold", 8'(mode), 8'h0);
            if (k == 6) check("deb_not_yet", 8'(btn_deb), 8'h0);
            if (k == 7) check("deb_rise", 8'(btn_deb), 8'h1);
        end
        tick(1);
        check("latency_adv", 8'(mode), 8'h1);
        btn_raw[0] = 1'b0;
        tick(10);
        check("release_no_adv", 8'(mode), 8'h1);
        for (int p = 0; p < 3; p++) begin
            btn_raw[0] = 1'b1;
            tick(10);
            btn_raw[0] = 1'b0;
            tick(10);
            check("press_seq", 8'(mode), 8'(press_exp[p]));
        end

        // Short glitch on ch1 is rejected; a 5-cycle pulse is one advance.
        btn_raw[1] = 1'b1;
        tick(3);
        btn_raw[1] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            check("glitch_deb", 8'(btn_deb), 8'h0);
        end
        check("glitch_mode", 8'(mode), 8'h0);
        btn_raw[1] = 1'b1;
        tick(5);
        btn_raw[1] = 1'b0;
        tick(12);
        check("pulse5_adv", 8'(mode), 8'b0100);

        // Asynchronous reset with ch0 held; held button re-debounces to exactly one advance.
        btn_raw[0] = 1'b1;
        tick(10);
        check("pre_reset_mode", 8'(mode), 8'b0101);
        check("pre_reset_led", 8'(led), 8'b11);
        rst_n = 1'b0;
        #1;
        check("async_rst_led", 8'(led), 8'h0);
        check("async_rst_mode", 8'(mode), 8'h0);
        check("async_rst_deb", 8'(btn_deb), 8'h0);
        tick(2);
        rst_n = 1'b1;
        tick(10);
        check("held_reset_adv", 8'(mode), 8'b0001);
        btn_raw[0] = 1'b0;
        tick(10);
        check("held_release", 8'(mode), 8'b0001);

        for (int i = 0; i < 10; i++) begin
            sw_step = vecs[i].step;
            sw_wr   = vecs[i].wr;
            sw_ch   = vecs[i].ch;
            sw_mode = vecs[i].md;
            tick(1);
            check($sformatf("vec%0d", i), 8'(mode), 8'(vecs[i].exp_mode));
        end
        sw_step = '0; sw_wr = 1'b0; sw_ch = 1'b0; sw_mode = '0;

        // Press and strobe on the same edge merge into one advance.
        btn_raw[0] = 1'b1;
        tick(7);
        check("merge_before", 8'(mode), 8'b0001);
        sw_step = 2'b01;
        tick(1);
        sw_step = '0;
        check("merge_adv", 8'(mode), 8'b0010);
        tick(6);
        check("merge_single", 8'(mode), 8'b0010);
        btn_raw[0] = 1'b0;
        tick(10);

        // Prescaler restarts from zero after reset; blink outputs follow its bits.
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        cnt_model = '0;
        sw_wr = 1'b1; sw_ch = 1'b0; sw_mode = 2'b10;
        tick(1);
        sw_ch = 1'b1; sw_mode = 2'b11;
        tick(1);
        sw_wr = 1'b0;
        check("blink_modes", 8'(mode), 8'b1110);
        for (int k = 0; k < 70; k++) begin
            logic [1:0] exp_led;
            exp_led = {cnt_model[3], cnt_model[5]};
            tick(1);
            check("blink_led", 8'(led), 8'(exp_led));
        end

        // Three-channel instance: out-of-range channel write is ignored.
        wr3 = 1'b1; ch3 = 2'd3; md3 = 2'b10;
        tick(1);
        check("wr_ch3_ignored", 8'(mode3), 8'h00);
        ch3 = 2'd2;
        tick(1);
        check("wr_ch2", 8'(mode3), 8'b100000);
        ch3 = 2'd1; md3 = 2'b01;
        tick(1);
        check("wr_ch1", 8'(mode3), 8'b100100);
        wr3 = 1'b0;
        tick(1);
        check("wr_hold", 8'(mode3), 8'b100100);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
